// File: rtl/lsu_pkg.sv
// Shared types, lane masks and address helpers for the load/store memory port.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_SECOND,
    ST_RESP,
    ST_ERR
  } state_e;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  // The unused encoding 2'b11 behaves as a word access.
  function automatic size_e decode_size(input logic [1:0] raw);
    case (raw)
      2'b01:   return SZ_HALF;
      2'b10:   return SZ_BYTE;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic [3:0] size_mask(input size_e sz);
    case (sz)
      SZ_BYTE: return MASK_BYTE;
      SZ_HALF: return MASK_HALF;
      default: return MASK_WORD;
    endcase
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [1:0] off);
    return (sz == SZ_HALF && off[0]) || (sz == SZ_WORD && off != 2'b00);
  endfunction

  function automatic logic crosses_word(input size_e sz, input logic [1:0] off);
    return (sz == SZ_HALF && off == 2'b11) || (sz == SZ_WORD && off != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Word-wide data-memory bus with a single-cycle req/ack handshake.
interface lsu_mem_port_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables, shifted store data, extracted and extended load data.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  size_e       size,
  input  logic        load_unsigned,
  input  logic        hi_beat,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_lo,
  input  logic [31:0] rdata_hi,
  output logic [3:0]  be,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);
  logic [7:0]  be_wide;
  logic [63:0] wdata_wide;
  logic [31:0] v;

  // Shifting over a two-word window yields the low-beat lanes in the lower
  // half and the spill-over lanes of a word-crossing access in the upper half.
  always_comb begin
    be_wide    = {4'b0000, size_mask(size)} << off;
    wdata_wide = {32'd0, wdata} << {off, 3'b000};
    be         = hi_beat ? be_wide[7:4] : be_wide[3:0];
    wdata_sh   = hi_beat ? wdata_wide[63:32] : wdata_wide[31:0];
    v          = 32'({rdata_hi, rdata_lo} >> {off, 3'b000});
    case (size)
      SZ_BYTE: rdata_ext = {{24{v[7] & ~load_unsigned}}, v[7:0]};
      SZ_HALF: rdata_ext = {{16{v[15] & ~load_unsigned}}, v[15:0]};
      default: rdata_ext = v;
    endcase
  end
endmodule

// File: rtl/lsu_mem_port.sv
// Load/store responder: one access at a time, stalls until done, misalign error or bus timeout.
// Define MISALIGN_SPLIT_EN to split word-crossing accesses into two beats instead of erroring.
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           mem_read,
  input  logic           mem_write,
  input  logic [1:0]     inst_size,
  input  logic           load_unsigned,
  input  logic [31:0]    addr,
  input  logic [31:0]    wdata,
  output logic [31:0]    rdata,
  output logic           done,
  output logic           stall,
  output logic           misalign_err,
  output logic           bus_err,
  lsu_mem_port_if.master bus
);
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  size_e            size_q, size_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             uns_q, uns_d;
  logic             we_q, we_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             berr_q, berr_d;
  logic [31:0]      rlo_q, rlo_d;

  logic             request, in_beat, timeout_hit, split_needed, misalign_now;
  logic [CNT_W-1:0] cnt_inc;
  size_e            size_in;
  logic [3:0]       lane_be;
  logic [31:0]      lane_wdata, lane_rdata, rd_lo, rd_hi;

  assign request     = mem_read | mem_write;
  assign size_in     = decode_size(inst_size);
  assign in_beat     = (state_q == ST_ACCESS) || (state_q == ST_SECOND);
  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == TMO);

`ifdef MISALIGN_SPLIT_EN
  assign misalign_now = 1'b0;
  assign split_needed = crosses_word(size_q, addr_q[1:0]);
`else
  assign misalign_now = misaligned(size_in, addr[1:0]);
  assign split_needed = 1'b0;
`endif

  // During the second beat the first beat's word supplies the low lanes.
  assign rd_lo = (state_q == ST_SECOND) ? rlo_q : bus.bus_rdata;
  assign rd_hi = (state_q == ST_SECOND) ? bus.bus_rdata : 32'd0;

  lsu_lane_align u_align (
    .off           (addr_q[1:0]),
    .size          (size_q),
    .load_unsigned (uns_q),
    .hi_beat       (state_q == ST_SECOND),
    .wdata         (wdata_q),
    .rdata_lo      (rd_lo),
    .rdata_hi      (rd_hi),
    .be            (lane_be),
    .wdata_sh      (lane_wdata),
    .rdata_ext     (lane_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= SZ_WORD;
      wdata_q <= '0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      berr_q  <= 1'b0;
      rlo_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      berr_q  <= berr_d;
      rlo_q   <= rlo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    uns_d   = uns_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    berr_d  = berr_q;
    rlo_d   = rlo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (request) begin
          addr_d  = addr;
          size_d  = size_in;
          wdata_d = wdata;
          uns_d   = load_unsigned;
          we_d    = mem_write;
          cnt_d   = '0;
          berr_d  = 1'b0;
          state_d = misalign_now ? ST_ERR : ST_ACCESS;
        end
      end
      ST_ACCESS, ST_SECOND: begin
        if (bus.bus_ack) begin
          cnt_d = '0;
          if (state_q == ST_ACCESS && split_needed) begin
            rlo_d   = bus.bus_rdata;
            state_d = ST_SECOND;
          end else begin
            if (!we_q) rdata_d = lane_rdata;
            state_d = ST_RESP;
          end
        end else if (timeout_hit) begin
          berr_d  = 1'b1;
          rdata_d = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RESP, ST_ERR: state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  assign bus.bus_req   = in_beat;
  assign bus.bus_we    = in_beat & we_q;
  assign bus.bus_addr  = in_beat ? ({addr_q[31:2], 2'b00} + ((state_q == ST_SECOND) ? 32'd4 : 32'd0)) : 32'd0;
  assign bus.bus_be    = in_beat ? lane_be : 4'd0;
  assign bus.bus_wdata = in_beat ? lane_wdata : 32'd0;

  assign done         = (state_q == ST_RESP) || (state_q == ST_ERR);
  assign misalign_err = (state_q == ST_ERR);
  assign bus_err      = (state_q == ST_RESP) && berr_q;
  // A request seen while reset is held must not stall the pipeline.
  assign stall        = ~reset & (((state_q == ST_IDLE) & request) | in_beat);
  assign rdata        = rdata_q;
endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomized bench for lsu_mem_port against a byte-level memory/transaction model.
`timescale 1ns/1ps
module tb_lsu_mem_port;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0, mem_write = 1'b0, load_unsigned = 1'b0;
  logic [1:0]  inst_size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        done, stall, misalign_err, bus_err;

  lsu_mem_port_if bus_if ();

  lsu_mem_port #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .inst_size     (inst_size),
    .load_unsigned (load_unsigned),
    .addr          (addr),
    .wdata         (wdata),
    .rdata         (rdata),
    .done          (done),
    .stall         (stall),
    .misalign_err  (misalign_err),
    .bus_err       (bus_err),
    .bus           (bus_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          delay;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] model_rdata = '0;
  logic        exp_mis = 1'b0, exp_berr = 1'b0;
  int          errors = 0, checks = 0;
  bit          busy = 0, done_seen = 0, mon_en = 0, stray_ack = 0;
  int          start_cyc = 0, last_req_cyc = 0, waited = 0, done_cnt = 0;
  logic [31:0] seen_addr[$], seen_wdata[$];
  logic [3:0]  seen_be[$];
  logic [31:0] last_rdata = '0;
  logic        last_mis = 1'b0, last_berr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] rd_word(input logic [31:0] wa);
    if (mem.exists(wa)) return mem[wa];
    return (wa * 32'h9E3779B1) ^ 32'hA5C31F07;
  endfunction

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    logic [31:0] w;
    w = rd_word({a[31:2], 2'b00});
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  // Model: split the access into bytes, group them by word into beats,
  // and assemble the expected load value from the byte view of memory.
  task automatic build(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input int d0, input int d1);
    int          n, nb;
    logic        mis;
    logic [31:0] ba, wa, val;
    logic [31:0] baddr [2];
    logic [3:0]  bbe [2];
    logic [31:0] bwd [2];
    beat_t       b;
    exp_q.delete();
    n   = (sz == 2'b01) ? 2 : (sz == 2'b10) ? 1 : 4;
    mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`ifdef MISALIGN_SPLIT_EN
    mis = 1'b0;
`endif
    exp_mis  = mis;
    exp_berr = 1'b0;
    if (mis) return;
    nb  = 0;
    val = '0;
    for (int i = 0; i < n; i++) begin
      ba = a + 32'(i);
      wa = {ba[31:2], 2'b00};
      if (nb == 0 || baddr[nb-1] != wa) begin
        baddr[nb] = wa; bbe[nb] = 4'b0000; bwd[nb] = '0; nb++;
      end
      bbe[nb-1][ba[1:0]] = 1'b1;
      bwd[nb-1][{ba[1:0], 3'b000} +: 8] = wd[8*i +: 8];
      val[8*i +: 8] = rd_byte(ba);
    end
    for (int j = 0; j < nb; j++) begin
      b.addr = baddr[j]; b.be = bbe[j]; b.we = wr; b.wdata = bwd[j];
      b.delay = (j == 0) ? d0 : d1;
      exp_q.push_back(b);
      if (b.delay < 0) begin
        exp_berr = 1'b1;
        break;
      end
    end
    if (exp_berr) model_rdata = '0;
    else if (rd && !wr) begin
      if (n == 1)      model_rdata = uns ? {24'd0, val[7:0]}  : {{24{val[7]}}, val[7:0]};
      else if (n == 2) model_rdata = uns ? {16'd0, val[15:0]} : {{16{val[15]}}, val[15:0]};
      else             model_rdata = val;
    end
  endtask

  // Memory responder and per-cycle compare against the model.
  initial begin
    beat_t b;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus_if.bus_ack) bus_if.bus_ack = 1'b0;
      if (stray_ack) begin
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = $urandom; stray_ack = 0;
      end
      if (done) done_cnt++;
      if (mon_en && !reset) begin
        if (bus_if.bus_req) begin
          last_req_cyc = cyc;
          chk("req_expected", 32'(exp_q.size() > 0), 32'd1);
          if (exp_q.size() > 0) begin
            b = exp_q[0];
            if (waited == 0) begin
              seen_addr.push_back(bus_if.bus_addr);
              seen_be.push_back(bus_if.bus_be);
              seen_wdata.push_back(bus_if.bus_wdata);
            end
            chk("bus_addr", bus_if.bus_addr, b.addr);
            chk("bus_be", 32'(bus_if.bus_be), 32'(b.be));
            chk("bus_we", 32'(bus_if.bus_we), 32'(b.we));
            if (b.we) chk("bus_wdata", bus_if.bus_wdata & lane_mask(b.be), b.wdata);
            if (b.delay >= 0 && waited == b.delay) begin
              bus_if.bus_ack   = 1'b1;
              bus_if.bus_rdata = rd_word(b.addr);
              if (b.we) mem[b.addr] = (rd_word(b.addr) & ~lane_mask(b.be)) | b.wdata;
              void'(exp_q.pop_front());
              waited = 0;
            end else begin
              waited++;
            end
          end
        end
        if (busy) begin
          if (done) begin
            chk("done_rdata", rdata, model_rdata);
            chk("done_misalign", 32'(misalign_err), 32'(exp_mis));
            chk("done_bus_err", 32'(bus_err), 32'(exp_berr));
            chk("done_stall", 32'(stall), 32'd0);
            if (exp_mis) chk("done_cycle", 32'(cyc), 32'(start_cyc + 1));
            else         chk("done_cycle", 32'(cyc), 32'(last_req_cyc + 1));
            if (exp_berr) begin
              chk("timeout_len", 32'(waited), 32'(TMO));
              chk("beats_left", 32'(exp_q.size()), 32'd1);
            end else begin
              chk("beats_left", 32'(exp_q.size()), 32'd0);
            end
            last_rdata = rdata; last_mis = misalign_err; last_berr = bus_err;
            exp_q.delete();
            waited = 0; busy = 0; done_seen = 1;
          end else begin
            chk("stall_busy", 32'(stall), 32'd1);
            chk("err_early", 32'({misalign_err, bus_err}), 32'd0);
          end
        end else begin
          chk("idle_quiet", 32'({done, stall, misalign_err, bus_err}), 32'd0);
        end
      end
    end
  end

  // Entered just after a rising edge; returns just after the edge ending the done cycle.
  task automatic run_txn(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd, input int d0, input int d1,
                         input bit scr);
    build(rd, wr, sz, uns, a, wd, d0, d1);
    seen_addr.delete(); seen_be.delete(); seen_wdata.delete();
    mem_read = rd; mem_write = wr; inst_size = sz; load_unsigned = uns; addr = a; wdata = wd;
    start_cyc = cyc; done_seen = 0; busy = 1;
    for (int k = 0; k < 200 && !done_seen; k++) begin
      @(posedge clk); #1;
      if (!done_seen && scr) begin
        addr = $urandom; wdata = $urandom;
        inst_size = 2'($urandom_range(0, 3)); load_unsigned = 1'($urandom_range(0, 1));
      end
    end
    chk("done_reached", 32'(done_seen), 32'd1);
    busy = 0;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int          d, op;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_flags", 32'({done, stall, misalign_err, bus_err}), 32'd0);
    chk("rst_bus_ctl", 32'({bus_if.bus_req, bus_if.bus_we, bus_if.bus_be}), 32'd0);
    chk("rst_bus_addr", bus_if.bus_addr, 32'd0);
    reset = 1'b0;
    mon_en = 1;
    @(posedge clk); #1;

    mem[32'h100] = 32'h80123456;
    run_txn(1, 0, 2'b10, 0, 32'h103, 32'h0, 1, 0, 0);
    chk("lb_0x103", last_rdata, 32'hFFFFFF80);
    run_txn(1, 0, 2'b10, 1, 32'h103, 32'h0, 0, 0, 0);
    chk("lbu_0x103", last_rdata, 32'h00000080);

    run_txn(0, 1, 2'b00, 0, 32'h100, 32'hDEADBEEF, 2, 0, 0);
    chk("sw_beats", 32'(seen_addr.size()), 32'd1);
    if (seen_addr.size() > 0) begin
      chk("sw_addr", seen_addr[0], 32'h100);
      chk("sw_be", 32'(seen_be[0]), 32'hF);
      chk("sw_wdata", seen_wdata[0], 32'hDEADBEEF);
    end

    run_txn(0, 1, 2'b01, 0, 32'h102, 32'h00001234, 0, 0, 0);
    if (seen_be.size() > 0) begin
      chk("sh_be", 32'(seen_be[0]), 32'hC);
      w = seen_wdata[0];
      chk("sh_wdata_hi", 32'(w[31:16]), 32'h1234);
    end

    mem[32'h100] = 32'h332211AA;
    mem[32'h104] = 32'hBBCCDD44;
    run_txn(1, 0, 2'b00, 0, 32'h101, 32'h0, 1, 2, 0);
`ifdef MISALIGN_SPLIT_EN
    chk("lw101_rdata", last_rdata, 32'h44332211);
    chk("lw101_beats", 32'(seen_addr.size()), 32'd2);
    if (seen_addr.size() > 1) begin
      chk("lw101_b0", {seen_addr[0][31:4], seen_be[0]}, {28'h010, 4'hE});
      chk("lw101_b1", {seen_addr[1][31:4], seen_be[1]}, {28'h010, 4'h1});
      chk("lw101_a1", seen_addr[1], 32'h104);
    end
`else
    chk("lw101_misalign", 32'({last_mis, last_berr}), 32'b10);
    chk("lw101_no_req", 32'(seen_addr.size()), 32'd0);
`endif

    // Asynchronous reset in the middle of a bus access.
    mon_en = 0;
    mem_read = 1'b1; inst_size = 2'b00; addr = 32'h200; load_unsigned = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_req_before", 32'(bus_if.bus_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_req", 32'(bus_if.bus_req), 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    mem_read = 1'b0; reset = 1'b0;
    d = done_cnt;
    stray_ack = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("stray_ack_no_done", 32'(done_cnt), 32'(d));
    chk("stray_ack_no_req", 32'(bus_if.bus_req), 32'd0);
    model_rdata = '0;
    mon_en = 1;
    run_txn(0, 1, 2'b00, 0, 32'h140, 32'hCAFEF00D, 1, 0, 0);
    chk("post_rst_sw", 32'({last_mis, last_berr}), 32'd0);

    run_txn(1, 0, 2'b00, 0, 32'h200, 32'h0, -1, 0, 0);
    chk("timeout_flags", 32'({last_mis, last_berr}), 32'b01);
    chk("timeout_rdata", last_rdata, 32'd0);

    for (int t = 0; t < 80; t++) begin
      op = $urandom_range(0, 3);
      run_txn(op != 1, op == 1 || op == 2, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              32'h100 + 32'($urandom_range(0, 63)), $urandom,
              ($urandom_range(0, 15) == 0) ? -1 : $urandom_range(0, 3),
              ($urandom_range(0, 15) == 0) ? -1 : $urandom_range(0, 3), 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
Load/store responder between the ID-stage control outputs (mem_read, mem_write, inst_size) and a word-wide data-memory bus with a req/ack handshake. Accepts one access at a time and computes the word address, byte enables and lane-shifted write data. On loads it extracts the addressed bytes and sign- or zero-extends them. Stalls the pipeline until the access completes, errors on a misaligned address, or times out.

Parameters:
TIMEOUT_CYCLES, 255, max ACCESS/SECOND cycles waiting for bus_ack before abort; 0 disables timeout
CNT_W, 8, width of timeout counter; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
mem_read  in  1  load request from decoder
mem_write  in  1  store request from decoder
inst_size  in  2  00 word, 01 half, 10 byte; 11 treated as word
load_unsigned  in  1  funct3[2]; zero-extend load result
addr  in  32  byte address from ALU
wdata  in  32  store data (rs2)
rdata  out  32  extended load result, valid while done=1
done  out  1  one-cycle completion pulse
stall  out  1  hold pipeline
misalign_err  out  1  one-cycle pulse with done on misaligned access
bus_err  out  1  one-cycle pulse with done on timeout
bus_req  out  1  bus request, held until ack
bus_we  out  1  1 = write
bus_addr  out  32  word-aligned address {a[31:2],2'b00}
bus_be  out  4  byte lane enables
bus_wdata  out  32  lane-shifted write data
bus_ack  in  1  bus completion, single cycle
bus_rdata  in  32  read data, valid with bus_ack

Behaviour:
- Reset: state IDLE. rdata=0. All other outputs are 0. bus_req drops asynchronously. A late bus_ack after reset is ignored.
- States: IDLE, ACCESS, SECOND (macro only), RESP, ERR.
- IDLE: mem_read|mem_write captures addr, size, wdata, unsigned and op. Both asserted → write wins.
  - Misaligned → ERR. Misaligned means half with a[0]=1, or word with a[1:0]≠0.
  - Otherwise → ACCESS.
- stall = (IDLE & request) | ACCESS | SECOND. stall is 0 in RESP and ERR.
- ACCESS: bus_req=1, bus_we=op.
  - bus_be: byte 0001<<off, half 0011<<off, word 1111.
  - bus_wdata = wdata<<(8*off), where off=a[1:0].
  - On bus_ack: register the extracted result → RESP.
- Extract: v = bus_rdata>>(8*off).
  - Byte: v[7:0] extended by v[7] or 0.
  - Half: v[15:0] extended likewise.
  - Word: v as-is.
  - Stores leave rdata unchanged.
- RESP: done=1 for one cycle → IDLE. A request is not re-accepted in RESP; the pipeline advances at the end of the done cycle.
- ERR: done=1 and misalign_err=1 for one cycle, no bus activity → IDLE.
- Timeout: counter clears on entry to ACCESS/SECOND and increments each cycle without ack.
  - At TIMEOUT_CYCLES: bus_req drops next edge, → RESP with bus_err=1 and rdata=0.
- Minimum latency: request cycle, ACCESS cycle with same-cycle ack, RESP cycle = done 2 cycles after acceptance.
- Inputs are sampled only in IDLE. Changes during stall are ignored.

Optional Feature:
MISALIGN_SPLIT_EN.
- Defined: misaligned accesses do not error.
- Contained in one word (half at off=1): single beat with shifted be and data.
- Crossing a word boundary (half off=3, word off≠0): ACCESS issues the low word with be=mask<<off and wdata<<8*off, then SECOND issues addr+4 with be=mask>>(4-off) and wdata>>8*(4-off).
- Read bytes are merged before extension. The timeout applies per beat. misalign_err is never asserted.
- Undefined: the ERR path above.

Decomposition:
- Package lsu_pkg: size encodings WORD/HALF/BYTE (00/01/10), state enum, lane-mask constants.
- One combinational sub-module lsu_lane_align: off, size, unsigned, wdata, rdata → be, shifted wdata, extended rdata.
- FSM, timeout counter and capture registers stay in lsu_mem_port.

Test Plan:
- sw addr 0x100, wdata 0xDEADBEEF, ack after 2 cycles → bus_addr 0x100, be 1111, bus_wdata 0xDEADBEEF; done 1 cycle after ack; stall low in the done cycle.
- lb addr 0x103, bus_rdata 0x80123456 → rdata 0xFFFFFF80; lbu same → 0x00000080.
- sh addr 0x102, wdata 0x00001234 → be 1100, bus_wdata[31:16] = 0x1234.
- lw addr 0x101:
  - Without macro → misalign_err+done pulse, bus_req never high.
  - With macro → beats 0x100 be 1110 and 0x104 be 0001; rdata 0x44332211 from bytes 0x11,0x22,0x33 (word0 lanes 1–3) and 0x44 (word1 lane 0).
- lw addr 0x200, ack never arrives, TIMEOUT_CYCLES=4 → bus_req drops after 4 cycles; bus_err+done pulse; rdata 0.
- reset pulse mid-ACCESS → bus_req 0 immediately, stall 0; a stray ack is ignored; the next sw completes normally.
